// File: rtl/time_of_day_sequencer.sv
// Keeps the DCF77 clock's 44-bit BCD time/date vector running: a 1 Hz tick drives a
// sec>min>hour>day>month>year carry chain; DCF or preset loads overwrite it after a range check.
module time_of_day_sequencer #(
    parameter int HOLDOVER_S = 3600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick1Hz_In,
    input  logic        dcfValid_In,
    input  logic [43:0] dcfTimeAndDate_In,
    input  logic        presetLoad_In,
    input  logic [43:0] presetTimeAndDate_In,
    output logic [43:0] timeAndDate_Out,
    output logic        synced_Out,
    output logic        busy_Out,
    output logic        reject_Out
);

    localparam int               CNT_W     = $clog2(HOLDOVER_S + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLDOVER_S);
    localparam logic [43:0]      TOD_RESET = 44'h300_0410_0000;

    typedef enum logic [2:0] {IDLE, C_MIN, C_HOUR, C_DAY, C_MON, C_YEAR} state_t;

    // Leap rule for 2000..2099 evaluated on BCD digits: year mod 4 == 0.
    function automatic logic is_leap(input logic [3:0] y_hi, input logic [3:0] y_lo);
        return (!y_hi[0] && (y_lo == 4'd0 || y_lo == 4'd4 || y_lo == 4'd8)) ||
               ( y_hi[0] && (y_lo == 4'd2 || y_lo == 4'd6));
    endfunction

    function automatic logic [5:0] month_len(input logic [4:0] mo, input logic [3:0] y_hi,
                                             input logic [3:0] y_lo);
        case (mo)
            5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
            5'h02:                      return is_leap(y_hi, y_lo) ? 6'h29 : 6'h28;
            default:                    return 6'h31;
        endcase
    endfunction

    function automatic logic range_ok(input logic [43:0] v);
        logic [5:0] day;
        logic [4:0] mo;
        logic       digits_ok;
        logic       hms_ok;
        day       = {v[25:24], v[23:20]};
        mo        = v[30:26];
        digits_ok = (v[3:0] <= 4'd9) && (v[10:7] <= 4'd9) && (v[17:14] <= 4'd9) &&
                    (v[23:20] <= 4'd9) && (v[29:26] <= 4'd9) && (v[34:31] <= 4'd9) &&
                    (v[38:35] <= 4'd9);
        hms_ok    = (v[6:4] <= 3'd5) && (v[13:11] <= 3'd5) &&
                    ((v[19:18] < 2'd2) || (v[19:18] == 2'd2 && v[17:14] <= 4'd3));
        return digits_ok && hms_ok && (mo >= 5'h01) && (mo <= 5'h12) && (day != 6'h00) &&
               (day <= month_len(mo, v[38:35], v[34:31])) && (v[41:39] != 3'd0);
    endfunction

    logic [43:0]      tod_q, tod_d;
    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             synced_q, synced_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             reject_q, reject_d;
    logic [5:0]       day_len;

    // NOTE: every always_comb target is defaulted first so no path can infer a latch.
    always_comb begin
        tod_d    = tod_q;
        state_d  = state_q;
        pend_d   = pend_q;
        synced_d = synced_q;
        hold_d   = hold_q;
        reject_d = 1'b0;
        day_len  = month_len(tod_q[30:26], tod_q[38:35], tod_q[34:31]);

        if (dcfValid_In) begin
            if (range_ok(dcfTimeAndDate_In)) begin
                tod_d    = dcfTimeAndDate_In;
                state_d  = IDLE;
                pend_d   = 1'b0;
                synced_d = 1'b1;
                hold_d   = '0;
            end else begin
                reject_d = 1'b1;
            end
        end else if (presetLoad_In) begin
            if (range_ok(presetTimeAndDate_In)) begin
                tod_d    = presetTimeAndDate_In;
                state_d  = IDLE;
                pend_d   = 1'b0;
                synced_d = 1'b0;
                hold_d   = '0;
            end else begin
                reject_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick1Hz_In || pend_q) begin
                        // A fresh tick landing on the pending-consume cycle stays queued.
                        pend_d = pend_q && tick1Hz_In;
                        if (tod_q[3:0] != 4'd9) begin
                            tod_d[3:0] = tod_q[3:0] + 4'd1;
                        end else begin
                            tod_d[3:0] = 4'd0;
                            if (tod_q[6:4] != 3'd5) begin
                                tod_d[6:4] = tod_q[6:4] + 3'd1;
                            end else begin
                                tod_d[6:4] = 3'd0;
                                state_d    = C_MIN;
                            end
                        end
                        if (synced_q) begin
                            if (hold_q != HOLD_MAX) hold_d = hold_q + CNT_W'(1);
                            if (hold_q >= HOLD_MAX - CNT_W'(1)) synced_d = 1'b0;
                        end
                    end
                end
                C_MIN: begin
                    state_d = IDLE;
                    if (tod_q[10:7] != 4'd9) begin
                        tod_d[10:7] = tod_q[10:7] + 4'd1;
                    end else begin
                        tod_d[10:7] = 4'd0;
                        if (tod_q[13:11] != 3'd5) begin
                            tod_d[13:11] = tod_q[13:11] + 3'd1;
                        end else begin
                            tod_d[13:11] = 3'd0;
                            state_d      = C_HOUR;
                        end
                    end
                end
                C_HOUR: begin
                    state_d = IDLE;
                    if (tod_q[19:18] == 2'd2 && tod_q[17:14] == 4'd3) begin
                        tod_d[19:14] = 6'h00;
                        tod_d[41:39] = (tod_q[41:39] == 3'd7) ? 3'd1 : tod_q[41:39] + 3'd1;
                        state_d      = C_DAY;
                    end else if (tod_q[17:14] == 4'd9) begin
                        tod_d[17:14] = 4'd0;
                        tod_d[19:18] = tod_q[19:18] + 2'd1;
                    end else begin
                        tod_d[17:14] = tod_q[17:14] + 4'd1;
                    end
                end
                C_DAY: begin
                    state_d = IDLE;
                    if (tod_q[25:20] == day_len) begin
                        tod_d[25:20] = 6'h01;
                        state_d      = C_MON;
                    end else if (tod_q[23:20] == 4'd9) begin
                        tod_d[23:20] = 4'd0;
                        tod_d[25:24] = tod_q[25:24] + 2'd1;
                    end else begin
                        tod_d[23:20] = tod_q[23:20] + 4'd1;
                    end
                end
                C_MON: begin
                    state_d = IDLE;
                    if (tod_q[30:26] == 5'h12) begin
                        tod_d[30:26] = 5'h01;
                        state_d      = C_YEAR;
                    end else if (tod_q[29:26] == 4'd9) begin
                        tod_d[30:26] = 5'h10;
                    end else begin
                        tod_d[29:26] = tod_q[29:26] + 4'd1;
                    end
                end
                C_YEAR: begin
                    state_d = IDLE;
                    if (tod_q[34:31] != 4'd9) begin
                        tod_d[34:31] = tod_q[34:31] + 4'd1;
                    end else begin
                        tod_d[34:31] = 4'd0;
                        tod_d[38:35] = (tod_q[38:35] == 4'd9) ? 4'd0 : tod_q[38:35] + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_q != IDLE && tick1Hz_In) pend_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tod_q    <= TOD_RESET;
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            synced_q <= 1'b0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            tod_q    <= tod_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            synced_q <= synced_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
        end
    end

    assign timeAndDate_Out = tod_q;
    assign synced_Out      = synced_q;
    assign busy_Out        = busy_q;
    assign reject_Out      = reject_q;

endmodule

// File: tb/tb_time_of_day_sequencer.sv
// Directed bench for time_of_day_sequencer: carry-chain rollovers, leap years, pending ticks,
// load priority, range rejects, holdover expiry and asynchronous reset mid-chain.
module tb_time_of_day_sequencer;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        dcf_valid;
    logic [43:0] dcf_tod;
    logic        preset_load;
    logic [43:0] preset_tod;
    logic [43:0] tod_out;
    logic        synced;
    logic        busy;
    logic        reject;

    int checks = 0;
    int errors = 0;

    localparam logic [43:0] TOD_RESET = 44'h300_0410_0000;

    time_of_day_sequencer #(.HOLDOVER_S(3)) dut (
        .clk                  (clk),
        .reset                (reset),
        .tick1Hz_In           (tick),
        .dcfValid_In          (dcf_valid),
        .dcfTimeAndDate_In    (dcf_tod),
        .presetLoad_In        (preset_load),
        .presetTimeAndDate_In (preset_tod),
        .timeAndDate_Out      (tod_out),
        .synced_Out           (synced),
        .busy_Out             (busy),
        .reject_Out           (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds the packed BCD vector from decimal fields.
    function automatic logic [43:0] mk_tod(input int tz, input int wd, input int yy, input int mo,
                                           input int dd, input int hh, input int mi, input int ss);
        logic [43:0] v;
        v        = '0;
        v[3:0]   = 4'(ss % 10);
        v[6:4]   = 3'(ss / 10);
        v[10:7]  = 4'(mi % 10);
        v[13:11] = 3'(mi / 10);
        v[17:14] = 4'(hh % 10);
        v[19:18] = 2'(hh / 10);
        v[23:20] = 4'(dd % 10);
        v[25:24] = 2'(dd / 10);
        v[29:26] = 4'(mo % 10);
        v[30]    = 1'(mo / 10);
        v[34:31] = 4'(yy % 10);
        v[38:35] = 4'(yy / 10);
        v[41:39] = 3'(wd);
        v[43:42] = 2'(tz);
        return v;
    endfunction

    task automatic load_preset(input logic [43:0] v);
        @(negedge clk);
        preset_tod  = v;
        preset_load = 1'b1;
        @(negedge clk);
        preset_load = 1'b0;
    endtask

    task automatic load_dcf(input logic [43:0] v);
        @(negedge clk);
        dcf_tod   = v;
        dcf_valid = 1'b1;
        @(negedge clk);
        dcf_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (tod_out !== TOD_RESET) begin
            errors++;
            $display("FAIL reset_tod: got %h expected %h", tod_out, TOD_RESET);
        end
        checks++;
        if (synced !== 1'b0) begin errors++; $display("FAIL reset_synced: got %b expected 0", synced); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b expected 0", reject); end
    endtask

    task automatic test_month_rollover();
        int n;
        load_preset(mk_tod(1, 2, 19, 7, 31, 23, 59, 45));
        checks++;
        if (tod_out !== mk_tod(1, 2, 19, 7, 31, 23, 59, 45)) begin
            errors++;
            $display("FAIL preset_load: got %h expected %h", tod_out, mk_tod(1, 2, 19, 7, 31, 23, 59, 45));
        end
        repeat (14) pulse_tick();
        checks++;
        if (tod_out !== mk_tod(1, 2, 19, 7, 31, 23, 59, 59)) begin
            errors++;
            $display("FAIL tick_count_59: got %h expected %h", tod_out, mk_tod(1, 2, 19, 7, 31, 23, 59, 59));
        end
        pulse_tick();
        checks++;
        if (tod_out[13:0] !== {3'd5, 4'd9, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL sec_latency: got %h expected %h", tod_out[13:0], {3'd5, 4'd9, 3'd0, 4'd0});
        end
        count_busy(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL month_busy_clks: got %0d expected 4", n); end
        checks++;
        if (tod_out !== mk_tod(1, 3, 19, 8, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL month_rollover: got %h expected %h", tod_out, mk_tod(1, 3, 19, 8, 1, 0, 0, 0));
        end
    endtask

    task automatic test_leap();
        logic [43:0] start_v [3];
        logic [43:0] exp_v   [3];
        start_v[0] = mk_tod(0, 5, 20, 2, 28, 23, 59, 59);  exp_v[0] = mk_tod(0, 6, 20, 2, 29, 0, 0, 0);
        start_v[1] = mk_tod(0, 4, 19, 2, 28, 23, 59, 59);  exp_v[1] = mk_tod(0, 5, 19, 3, 1, 0, 0, 0);
        start_v[2] = mk_tod(2, 6, 20, 2, 29, 23, 59, 59);  exp_v[2] = mk_tod(2, 7, 20, 3, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            load_preset(start_v[i]);
            pulse_tick();
            repeat (7) @(negedge clk);
            checks++;
            if (tod_out !== exp_v[i]) begin
                errors++;
                $display("FAIL leap_case%0d: got %h expected %h", i, tod_out, exp_v[i]);
            end
        end
    endtask

    task automatic test_century();
        int n;
        load_preset(mk_tod(0, 7, 99, 12, 31, 23, 59, 59));
        pulse_tick();
        count_busy(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL century_busy_clks: got %0d expected 5", n); end
        checks++;
        if (tod_out !== mk_tod(0, 1, 0, 1, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL century_wrap: got %h expected %h", tod_out, mk_tod(0, 1, 0, 1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        load_preset(mk_tod(0, 1, 21, 5, 10, 0, 59, 59));
        @(negedge clk);
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (tod_out !== mk_tod(0, 1, 21, 5, 10, 1, 0, 1)) begin
            errors++;
            $display("FAIL pending_tick: got %h expected %h", tod_out, mk_tod(0, 1, 21, 5, 10, 1, 0, 1));
        end
    endtask

    task automatic test_priority();
        logic [43:0] d;
        d = mk_tod(2, 1, 21, 3, 15, 12, 34, 56);
        @(negedge clk);
        dcf_tod     = d;
        dcf_valid   = 1'b1;
        preset_tod  = mk_tod(0, 3, 22, 6, 1, 8, 0, 0);
        preset_load = 1'b1;
        tick        = 1'b1;
        @(negedge clk);
        dcf_valid   = 1'b0;
        preset_load = 1'b0;
        tick        = 1'b0;
        checks++;
        if (tod_out !== d) begin errors++; $display("FAIL priority_dcf: got %h expected %h", tod_out, d); end
        checks++;
        if (synced !== 1'b1) begin errors++; $display("FAIL priority_synced: got %b expected 1", synced); end
        checks++;
        if (reject !== 1'b0) begin errors++; $display("FAIL priority_reject: got %b expected 0", reject); end
        repeat (3) @(negedge clk);
        checks++;
        if (tod_out !== d) begin errors++; $display("FAIL priority_tick_dropped: got %h expected %h", tod_out, d); end
    endtask

    task automatic test_reject();
        logic [43:0] d;
        logic [43:0] bad [4];
        d      = mk_tod(2, 1, 21, 3, 15, 12, 34, 56);
        bad[0] = mk_tod(2, 1, 21, 13, 15, 12, 34, 56);
        bad[1] = mk_tod(0, 2, 21, 5, 4, 24, 0, 0);
        bad[2] = mk_tod(0, 2, 21, 4, 31, 10, 0, 0);
        bad[3] = mk_tod(0, 0, 21, 5, 4, 10, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) load_dcf(bad[i]);
            else        load_preset(bad[i]);
            checks++;
            if (reject !== 1'b1) begin errors++; $display("FAIL reject_pulse%0d: got %b expected 1", i, reject); end
            checks++;
            if (tod_out !== d) begin errors++; $display("FAIL reject_unchanged%0d: got %h expected %h", i, tod_out, d); end
            @(negedge clk);
        end
        checks++;
        if (reject !== 1'b0) begin errors++; $display("FAIL reject_single_cycle: got %b expected 0", reject); end
        checks++;
        if (synced !== 1'b1) begin errors++; $display("FAIL reject_keeps_sync: got %b expected 1", synced); end
    endtask

    task automatic test_holdover();
        logic exp_sync [3];
        exp_sync[0] = 1'b1;
        exp_sync[1] = 1'b1;
        exp_sync[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            checks++;
            if (synced !== exp_sync[i]) begin
                errors++;
                $display("FAIL holdover_tick%0d: got %b expected %b", i + 1, synced, exp_sync[i]);
            end
        end
        checks++;
        if (tod_out !== mk_tod(2, 1, 21, 3, 15, 12, 34, 59)) begin
            errors++;
            $display("FAIL holdover_time: got %h expected %h", tod_out, mk_tod(2, 1, 21, 3, 15, 12, 34, 59));
        end
        load_dcf(mk_tod(0, 4, 22, 9, 1, 6, 0, 0));
        checks++;
        if (synced !== 1'b1) begin errors++; $display("FAIL resync: got %b expected 1", synced); end
        load_preset(mk_tod(0, 4, 22, 9, 1, 7, 0, 0));
        checks++;
        if (synced !== 1'b0) begin errors++; $display("FAIL preset_unsync: got %b expected 0", synced); end
    endtask

    task automatic test_reset_mid_chain();
        load_dcf(mk_tod(0, 7, 99, 12, 31, 23, 59, 59));
        pulse_tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tod_out !== TOD_RESET) begin
            errors++;
            $display("FAIL midreset_tod: got %h expected %h", tod_out, TOD_RESET);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++;
        if (synced !== 1'b0) begin errors++; $display("FAIL midreset_synced: got %b expected 0", synced); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tod_out !== TOD_RESET) begin
            errors++;
            $display("FAIL midreset_idle_tod: got %h expected %h", tod_out, TOD_RESET);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle_busy: got %b expected 0", busy); end
    endtask

    initial begin
        reset       = 1'b1;
        tick        = 1'b0;
        dcf_valid   = 1'b0;
        dcf_tod     = '0;
        preset_load = 1'b0;
        preset_tod  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_month_rollover();
        test_leap();
        test_century();
        test_back_to_back();
        test_priority();
        test_reject();
        test_holdover();
        test_reset_mid_chain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
